// File: rtl/dual_slope_seq.sv
// Dual-slope conversion sequencer: scans N_CH inputs through auto-zero, integrate and deintegrate,
// returning signed counts over valid/ready. Define AUTORANGE_EN for per-channel autoranging.
module dual_slope_seq #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned AZ_CYCLES  = 512,
    parameter int unsigned INT_CYCLES = 16384,
    parameter int unsigned N_CH       = 4,
    parameter int unsigned RANGE_W    = 3,
    localparam int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               en_i,
    input  logic               ref_ok_i,
    input  logic               comp_i,
    input  logic               sat_hi_i,
    input  logic               sat_lo_i,
    input  logic [RANGE_W-1:0] range_cfg_i,
    output logic [1:0]         afe_sel_o,
    output logic               afe_reset_o,
    output logic               ref_sign_o,
    output logic [CH_W-1:0]    ch_sel_o,
    output logic [RANGE_W-1:0] range_sel_o,
    output logic [CNT_W-1:0]   result_o,
    output logic               result_neg_o,
    output logic [CH_W-1:0]    result_ch_o,
    output logic               result_ovf_o,
    output logic               range_err_o,
    output logic               result_valid_o,
    input  logic               result_ready_i,
    output logic               busy_o
);

    typedef enum logic [2:0] {
        S_WAIT_REF,
        S_IDLE,
        S_AZ,
        S_INT,
        S_DEINT,
        S_RANGE,
        S_RESULT
    } state_t;

    localparam logic [CNT_W-1:0] AZ_LAST  = CNT_W'(AZ_CYCLES - 1);
    localparam logic [CNT_W-1:0] INT_LAST = CNT_W'(INT_CYCLES - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic               comp_q, comp_d;
    logic               ref_sign_q, ref_sign_d;
    logic [CNT_W-1:0]   cap_cnt_q, cap_cnt_d;
    logic               cap_ovf_q, cap_ovf_d;
    logic               cap_err_q, cap_err_d;
    logic               loaded_q, loaded_d;
    logic [CNT_W-1:0]   result_q, result_d;
    logic               result_neg_q, result_neg_d;
    logic [CH_W-1:0]    result_ch_q, result_ch_d;
    logic               result_ovf_q, result_ovf_d;
    logic               range_err_q, range_err_d;
    logic               valid_q, valid_d;

`ifdef AUTORANGE_EN
    logic [RANGE_W-1:0] range_q [N_CH];
    logic [RANGE_W-1:0] range_d [N_CH];
`else
    logic [RANGE_W-1:0] range_sel_q, range_sel_d;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ch_d         = ch_q;
        comp_d       = comp_q;
        ref_sign_d   = ref_sign_q;
        cap_cnt_d    = cap_cnt_q;
        cap_ovf_d    = cap_ovf_q;
        cap_err_d    = cap_err_q;
        loaded_d     = loaded_q;
        result_d     = result_q;
        result_neg_d = result_neg_q;
        result_ch_d  = result_ch_q;
        result_ovf_d = result_ovf_q;
        range_err_d  = range_err_q;
        valid_d      = valid_q;
`ifdef AUTORANGE_EN
        range_d      = range_q;
`else
        range_sel_d  = range_cfg_i;
`endif

        // A pending result can be accepted in any state, including after a reference loss.
        if (valid_q && result_ready_i) begin
            valid_d = 1'b0;
        end

        if (!ref_ok_i) begin
            state_d = S_WAIT_REF;
        end else begin
            case (state_q)
                S_WAIT_REF: begin
                    cap_err_d = 1'b0;
                    state_d   = S_IDLE;
                end
                S_IDLE: begin
                    if (en_i) begin
                        state_d = S_AZ;
                    end
                end
                S_AZ, S_INT, S_DEINT: begin
                    if (sat_hi_i || sat_lo_i) begin
                        state_d = S_RANGE;
`ifdef AUTORANGE_EN
                        if (sat_hi_i) begin
                            if (range_q[ch_q] == '1) begin
                                cap_err_d = 1'b1;
                            end else begin
                                range_d[ch_q] = range_q[ch_q] + 1'b1;
                            end
                        end else begin
                            if (range_q[ch_q] == '0) begin
                                cap_err_d = 1'b1;
                            end else begin
                                range_d[ch_q] = range_q[ch_q] - 1'b1;
                            end
                        end
`else
                        cap_err_d = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        case (state_q)
                            S_AZ: begin
                                if (cnt_q == AZ_LAST) begin
                                    state_d = S_INT;
                                end
                            end
                            S_INT: begin
                                if (cnt_q == INT_LAST) begin
                                    comp_d     = comp_i;
                                    ref_sign_d = ~comp_i;
                                    state_d    = S_DEINT;
                                end
                            end
                            default: begin
                                if (comp_i != comp_q) begin
                                    cap_cnt_d = cnt_q;
                                    cap_ovf_d = 1'b0;
                                    state_d   = S_RESULT;
                                end else if (cnt_q == '1) begin
                                    cap_cnt_d = cnt_q;
                                    cap_ovf_d = 1'b1;
                                    state_d   = S_RESULT;
                                end
                            end
                        endcase
                    end
                end
                S_RANGE: begin
                    state_d = cap_err_q ? S_RESULT : S_AZ;
                end
                S_RESULT: begin
                    // Load once the previous result (if any) is gone or leaving on this edge.
                    if (!loaded_q) begin
                        if (!valid_q || result_ready_i) begin
                            result_d     = cap_err_q ? '0 : cap_cnt_q;
                            result_neg_d = cap_err_q ? 1'b0 : ref_sign_q;
                            result_ovf_d = cap_err_q ? 1'b0 : cap_ovf_q;
                            range_err_d  = cap_err_q;
                            result_ch_d  = ch_q;
                            valid_d      = 1'b1;
                            loaded_d     = 1'b1;
                            cap_err_d    = 1'b0;
                        end
                    end else if (valid_q && result_ready_i) begin
                        ch_d    = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
                        state_d = en_i ? S_AZ : S_IDLE;
                    end
                end
                default: begin
                    state_d = S_WAIT_REF;
                end
            endcase
        end

        if (state_d != state_q) begin
            cnt_d    = '0;
            loaded_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_WAIT_REF;
            cnt_q        <= '0;
            ch_q         <= '0;
            comp_q       <= 1'b0;
            ref_sign_q   <= 1'b0;
            cap_cnt_q    <= '0;
            cap_ovf_q    <= 1'b0;
            cap_err_q    <= 1'b0;
            loaded_q     <= 1'b0;
            result_q     <= '0;
            result_neg_q <= 1'b0;
            result_ch_q  <= '0;
            result_ovf_q <= 1'b0;
            range_err_q  <= 1'b0;
            valid_q      <= 1'b0;
`ifdef AUTORANGE_EN
            range_q      <= '{default: '0};
`else
            range_sel_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ch_q         <= ch_d;
            comp_q       <= comp_d;
            ref_sign_q   <= ref_sign_d;
            cap_cnt_q    <= cap_cnt_d;
            cap_ovf_q    <= cap_ovf_d;
            cap_err_q    <= cap_err_d;
            loaded_q     <= loaded_d;
            result_q     <= result_d;
            result_neg_q <= result_neg_d;
            result_ch_q  <= result_ch_d;
            result_ovf_q <= result_ovf_d;
            range_err_q  <= range_err_d;
            valid_q      <= valid_d;
`ifdef AUTORANGE_EN
            range_q      <= range_d;
`else
            range_sel_q  <= range_sel_d;
`endif
        end
    end

    always_comb begin
        afe_sel_o   = 2'b00;
        afe_reset_o = 1'b0;
        busy_o      = 1'b1;
        case (state_q)
            S_WAIT_REF, S_IDLE: begin
                afe_reset_o = 1'b1;
                busy_o      = 1'b0;
            end
            S_AZ:    afe_sel_o = 2'b01;
            S_INT:   afe_sel_o = 2'b10;
            S_DEINT: afe_sel_o = 2'b11;
            default: afe_reset_o = 1'b1;
        endcase
    end

    assign ref_sign_o     = ref_sign_q;
    assign ch_sel_o       = ch_q;
    assign result_o       = result_q;
    assign result_neg_o   = result_neg_q;
    assign result_ch_o    = result_ch_q;
    assign result_ovf_o   = result_ovf_q;
    assign range_err_o    = range_err_q;
    assign result_valid_o = valid_q;
`ifdef AUTORANGE_EN
    assign range_sel_o    = range_q[ch_q];
`else
    assign range_sel_o    = range_sel_q;
`endif

endmodule
